// File: rtl/memory_port_arbiter_if.sv
// Per-core request/response bundle between the MEM-stage data ports and the
// shared memory port arbiter. Core i owns bits [32*i+31:32*i] of the wide fields.
interface memory_port_arbiter_if #(
    parameter int NUM_CORES = 2
);
    logic [NUM_CORES-1:0]    req_valid;
    logic [NUM_CORES-1:0]    req_ready;
    logic [NUM_CORES*32-1:0] req_address;
    logic [NUM_CORES*32-1:0] req_write_data;
    logic [NUM_CORES-1:0]    req_write_enable;
    logic [NUM_CORES*4-1:0]  req_byte_enable;
    logic [NUM_CORES-1:0]    resp_valid;
    logic [31:0]             resp_read_data;

    modport master (
        output req_valid, req_address, req_write_data, req_write_enable, req_byte_enable,
        input  req_ready, resp_valid, resp_read_data
    );

    modport slave (
        input  req_valid, req_address, req_write_data, req_write_enable, req_byte_enable,
        output req_ready, resp_valid, resp_read_data
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter placing one core request at a time on main_memory port B
// and routing the registered 1-cycle read back to the granted core.
module memory_port_arbiter #(
    parameter int NUM_CORES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    memory_port_arbiter_if.slave bus,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_write_data,
    output logic                 mem_write_enable,
    output logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_read_data
);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;

    logic [GW-1:0] winner;
    logic [GW-1:0] cand;
    logic          any_valid;

    // Round-robin search starting just after the last granted core.
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        winner    = last_grant_q;
        cand      = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = GW'((int'(last_grant_q) + i) % NUM_CORES);
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        be_d         = be_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d      = ACCESS;
                    last_grant_d = winner;
                    addr_d       = bus.req_address[32*winner +: 32];
                    wdata_d      = bus.req_write_data[32*winner +: 32];
                    we_d         = bus.req_write_enable[winner];
                    be_d         = bus.req_byte_enable[4*winner +: 4];
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and response strobes; both are silenced while reset is asserted.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        if (!rst && state_q == IDLE && any_valid) begin
            bus.req_ready[winner] = 1'b1;
        end
        if (!rst && state_q == RESP) begin
            bus.resp_valid[last_grant_q] = 1'b1;
        end
    end

    assign bus.resp_read_data = mem_read_data;

    // Memory fields hold their latched values; only the write strobe is gated.
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_byte_enable  = be_q;
    assign mem_write_enable = (state_q == ACCESS) && we_q && !rst;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_CORES - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            be_q         <= be_d;
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: table-driven transactions plus
// corner-case sequences, with a response scoreboard and a byte-lane memory model.
module tb_memory_port_arbiter;
    localparam int NC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_read_data = '0;

    memory_port_arbiter_if #(.NUM_CORES(NC)) bus ();

    memory_port_arbiter #(.NUM_CORES(NC)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_byte_enable  (mem_byte_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: registered read, byte-lane writes, single-writer backdoor port.
    logic [31:0] mem [0:16383];
    logic        bd_en = 1'b0;
    logic [13:0] bd_a = '0;
    logic [31:0] bd_d = '0;

    always @(posedge clk) begin
        if (bd_en) begin
            mem[bd_a] <= bd_d;
        end else if (mem_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_enable[b]) mem[mem_address[15:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
            end
        end
        mem_read_data <= mem[mem_address[15:2]];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          core;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t sb[$];

    // Scoreboard monitor, sampling mid-cycle after inputs have settled.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0 && cyc == sb[0].due - 1) begin
                check("mem_address", mem_address, sb[0].addr);
                check("mem_we", {31'd0, mem_write_enable}, {31'd0, sb[0].we});
                check("mem_be", {28'd0, mem_byte_enable}, {28'd0, sb[0].be});
                if (sb[0].we) check("mem_wdata", mem_write_data, sb[0].wdata);
            end else if (mem_write_enable !== 1'b0) begin
                check("mem_we_outside_access", {31'd0, mem_write_enable}, 32'd0);
            end
            if (bus.resp_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", {30'd0, bus.resp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_core", {30'd0, bus.resp_valid}, 32'(1 << e.core));
                    check("resp_cycle", cyc, e.due);
                    if (!e.we) check("resp_data", bus.resp_read_data, e.data);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                check("resp_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input int core, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] data, input int t);
        sb_t e;
        e.core = core; e.we = we; e.addr = addr; e.wdata = wdata;
        e.be = be; e.data = data; e.due = t + 2;
        sb.push_back(e);
    endtask

    task automatic drive(input int core, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [3:0] be);
        bus.req_address[32*core +: 32]    = addr;
        bus.req_write_data[32*core +: 32] = wdata;
        bus.req_write_enable[core]        = we;
        bus.req_byte_enable[4*core +: 4]  = be;
        bus.req_valid[core]               = 1'b1;
    endtask

    // Called at a negedge with the request already driven; returns inside the accept cycle.
    task automatic wait_ready(input int core, output bit got, output int t);
        got = 1'b0;
        t   = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (bus.req_ready[core]) begin
                got = 1'b1;
                t   = cyc;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("accept_core%0d", core), {31'd0, got}, 32'd1);
    endtask

    task automatic issue(input int core, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [3:0] be, input logic [31:0] exp);
        bit got;
        int t;
        @(negedge clk);
        drive(core, addr, wdata, we, be);
        wait_ready(core, got, t);
        if (got) push(core, we, addr, wdata, be, exp, t);
        @(negedge clk);
        bus.req_valid[core] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #4;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic backdoor(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_en = 1'b1; bd_a = a; bd_d = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    typedef struct {
        int          core;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit got;
        int t;
        int n;
        int last_t;

        vecs[0] = '{0, 32'h100, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF};
        vecs[1] = '{1, 32'h200, 32'h000000AB, 1'b1, 4'b0001, 32'h0};
        vecs[2] = '{1, 32'h200, 32'h0,        1'b0, 4'hF, 32'h112233AB};
        vecs[3] = '{0, 32'h204, 32'hCAFEF00D, 1'b1, 4'hF, 32'h0};
        vecs[4] = '{1, 32'h204, 32'h0,        1'b0, 4'hF, 32'hCAFEF00D};
        vecs[5] = '{0, 32'h208, 32'h12345678, 1'b1, 4'b1100, 32'h0};
        vecs[6] = '{0, 32'h208, 32'h0,        1'b0, 4'hF, 32'h1234AAAA};
        vecs[7] = '{1, 32'h20C, 32'h00FFEE00, 1'b1, 4'b0110, 32'h0};
        vecs[8] = '{0, 32'h20C, 32'h0,        1'b0, 4'hF, 32'h55FFEE55};
        vecs[9] = '{1, 32'h100, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF};

        bus.req_valid        = '0;
        bus.req_address      = '0;
        bus.req_write_data   = '0;
        bus.req_write_enable = '0;
        bus.req_byte_enable  = '0;

        // Preload memory while the arbiter is held in reset.
        backdoor(14'h040, 32'hDEADBEEF);
        backdoor(14'h080, 32'h11223344);
        backdoor(14'h082, 32'hAAAAAAAA);
        backdoor(14'h083, 32'h55555555);
        backdoor(14'h084, 32'h44444444);
        backdoor(14'h085, 32'h99999999);
        backdoor(14'h0C0, 32'h77777777);
        backdoor(14'h100, 32'h0A0A0A0A);
        backdoor(14'h101, 32'h0B0B0B0B);

        // Reset state, with both cores already requesting.
        drive(0, 32'h400, 32'h0, 1'b0, 4'hF);
        drive(1, 32'h404, 32'h0, 1'b0, 4'hF);
        @(negedge clk);
        #1;
        check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
        check("rst_resp", {30'd0, bus.resp_valid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);

        // Contention from reset: alternating grants three cycles apart.
        @(negedge clk);
        rst    = 1'b0;
        n      = 0;
        last_t = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.req_ready !== '0) begin
                check("rr_grant", {30'd0, bus.req_ready}, 32'(1 << (n % 2)));
                if (n > 0) check("rr_spacing", cyc - last_t, 3);
                last_t = cyc;
                if (n % 2 == 0) push(0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0A0A0A0A, cyc);
                else            push(1, 1'b0, 32'h404, 32'h0, 4'hF, 32'h0B0B0B0B, cyc);
                n++;
            end
            if (n == 4) break;
            @(negedge clk);
        end
        check("rr_grant_count", n, 4);
        @(negedge clk);
        bus.req_valid = '0;
        drain();

        // Table of single transactions.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].core, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].be, vecs[i].exp);
        end
        drain();

        // Request fields change the cycle after acceptance.
        @(negedge clk);
        drive(0, 32'h210, 32'h600DF00D, 1'b1, 4'hF);
        wait_ready(0, got, t);
        if (got) push(0, 1'b1, 32'h210, 32'h600DF00D, 4'hF, 32'h0, t);
        @(negedge clk);
        drive(0, 32'h214, 32'hFFFFFFFF, 1'b0, 4'h0);
        bus.req_valid[0] = 1'b0;
        drain();
        issue(0, 32'h210, 32'h0, 1'b0, 4'hF, 32'h600DF00D);
        issue(1, 32'h214, 32'h0, 1'b0, 4'hF, 32'h99999999);
        drain();

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        drive(0, 32'h300, 32'hBAD0BAD0, 1'b1, 4'hF);
        wait_ready(0, got, t);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_mem_we", {31'd0, mem_write_enable}, 32'd0);
        check("abort_resp", {30'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 32'h300, 32'h0, 1'b0, 4'hF);
        drive(1, 32'h400, 32'h0, 1'b0, 4'hF);
        #1;
        check("abort_prio_core0", {30'd0, bus.req_ready}, 32'd1);
        if (bus.req_ready[0]) push(0, 1'b0, 32'h300, 32'h0, 4'hF, 32'h77777777, cyc);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_ready(1, got, t);
        if (got) push(1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0A0A0A0A, t);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        drain();
        check("abort_mem_unchanged", mem[14'h0C0], 32'h77777777);

        // Idle: nothing requested for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            check("idle_quiet", {27'd0, bus.req_ready, bus.resp_valid, mem_write_enable}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
